// File: rtl/page_walker.sv
// page_walker: round-robin multi-port Sv39/Sv48 page-table walker with a single-entry translation cache.
// Serves one request at a time; mem_req_addr is held steady for the whole FETCH cycle.
module page_walker #(
    parameter int NPORTS = 2,
    parameter int LEVELS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      req_valid,
    input  logic [NPORTS*64-1:0]   req_addr,
    output logic [NPORTS-1:0]      resp_valid,
    output logic [63:0]            resp_addr,
    output logic [7:0]             resp_perms,
    output logic                   resp_fault,
    output logic                   mem_req_valid,
    output logic [63:0]            mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [63:0]            mem_resp_data,
    input  logic [63:0]            root_pt_addr,
    input  logic                   flush,
    output logic                   busy
);
    localparam int VAW = 12 + 9 * LEVELS;
    localparam int TW  = 9 * LEVELS;
    localparam int PW  = NPORTS > 1 ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr, port, grant;
    logic [PW:0]     idx;
    logic [63:0]     va, pt, pte, sel_va, base, lo_mask;
    logic [1:0]      level, cache_level;
    logic            fault, cache_valid, found, accept, canon, hit, is_ptr, bad, step, deliver;
    logic [TW-1:0]   cache_tag;
    logic [63:0]     cache_pte;
    logic [5:0]      sh;
    logic [43:0]     ppn_in;
    logic [63:0]     addrs [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_addr
        assign addrs[i] = req_addr[64*i +: 64];
    end

    // Round-robin: first requesting port at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NPORTS)) idx = idx - (PW+1)'(NPORTS);
            if (!found && req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                grant = idx[PW-1:0];
            end
        end
    end

    assign sel_va  = addrs[grant];
    assign accept  = state == IDLE && found && !flush;
    assign canon   = &sel_va[63:VAW-1] || ~|sel_va[63:VAW-1];
    assign hit     = cache_valid && cache_tag == sel_va[VAW-1:12];
    assign sh      = 6'd12 + 6'd9 * 6'(level);
    assign ppn_in  = mem_resp_data[53:10];
    assign is_ptr  = ~|mem_resp_data[3:1];
    // Invalid PTE, reserved W-without-R, pointer at the last level, or a misaligned superpage.
    assign bad     = !mem_resp_data[0] || (mem_resp_data[2] && !mem_resp_data[1]) ||
                     (is_ptr && level == 2'd0) ||
                     (!is_ptr && |(ppn_in & ((44'd1 << (sh - 6'd12)) - 44'd1)));
    assign step    = state == FETCH && mem_resp_valid && !flush;
    assign lo_mask = (64'd1 << sh) - 64'd1;
    assign base    = {8'b0, pte[53:10], 12'b0};
    assign deliver = state == DONE && req_valid[port] && addrs[port][63:12] == va[63:12];

    always_comb begin
        busy          = state != IDLE;
        mem_req_valid = state == FETCH;
        mem_req_addr  = state == FETCH ? {pt[63:12], 9'(va >> sh), 3'b000} : '0;
        resp_valid    = deliver ? NPORTS'(1) << port : '0;
        resp_fault    = deliver && fault;
        resp_perms    = deliver && !fault ? pte[7:0] : '0;
        resp_addr     = deliver && !fault ? ((base & ~lo_mask) | (va & lo_mask)) & ~64'hfff : '0;
        state_nx      = state == IDLE  ? (accept ? ((!canon || hit) ? DONE : FETCH) : IDLE) :
                        state == FETCH ? (flush ? IDLE : !mem_resp_valid ? FETCH :
                                          (bad || !is_ptr) ? DONE : FETCH) :
                        IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            port        <= '0;
            va          <= '0;
            pt          <= '0;
            pte         <= '0;
            level       <= '0;
            fault       <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_pte   <= '0;
            cache_level <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                port   <= grant;
                rr_ptr <= grant == PW'(NPORTS - 1) ? '0 : grant + 1'b1;
                va     <= sel_va;
                pt     <= root_pt_addr;
                fault  <= !canon;
                pte    <= canon && hit ? cache_pte : '0;
                level  <= canon && hit ? cache_level : 2'(LEVELS - 1);
            end
            if (step) begin
                if (bad) fault <= 1'b1;
                else if (is_ptr) begin
                    pt    <= {8'b0, mem_resp_data[53:10], 12'b0};
                    level <= level - 2'd1;
                end else begin
                    pte         <= mem_resp_data;
                    cache_valid <= 1'b1;
                    cache_tag   <= va[VAW-1:12];
                    cache_pte   <= mem_resp_data;
                    cache_level <= level;
                end
            end
            if (flush) cache_valid <= 1'b0;
        end
    end
endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of translation request ports (1..8).
REQ-002 SHALL have parameter LEVELS, default 4, page-table levels (3 = Sv39, 4 = Sv48); VA width VAW = 12+9*LEVELS.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  NPORTS  per-port translation request.
REQ-006 SHALL have port req_addr  input  NPORTS*64  per-port virtual address, port p in bits [64p+63:64p].
REQ-007 SHALL have port resp_valid  output  NPORTS  one-hot response strobe for the served port.
REQ-008 SHALL have port resp_addr  output  64  translated page address, bits [11:0] zero.
REQ-009 SHALL have port resp_perms  output  8  leaf PTE bits [7:0] (DAGUXWRV).
REQ-010 SHALL have port resp_fault  output  1  translation failed; qualified by resp_valid.
REQ-011 SHALL have port mem_req_valid  output  1  PTE read request to D$ (physical).
REQ-012 SHALL have port mem_req_addr  output  64  PTE physical address.
REQ-013 SHALL have port mem_resp_valid  input  1  PTE data valid.
REQ-014 SHALL have port mem_resp_data  input  64  PTE data.
REQ-015 SHALL have port root_pt_addr  input  64  root page-table physical address.
REQ-016 SHALL have port flush  input  1  invalidate cached translation / abort walk.
REQ-017 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement states IDLE, FETCH, DONE.
REQ-019 In IDLE with any req_valid and no flush, SHALL accept one port by round-robin: lowest index >= rr_ptr (wrapping); rr_ptr <= grant+1 mod NPORTS on accept.
REQ-020 On accept SHALL latch port, VA, root_pt_addr; level <= LEVELS-1.
REQ-021 Non-canonical VA (bits [63:VAW] not all equal to bit VAW-1) SHALL go directly to DONE with fault, no memory access.
REQ-022 Cache hit (single entry valid and tag == VA[VAW-1:12]) SHALL go directly to DONE with cached PTE and level, no memory access; else FETCH.
REQ-023 In FETCH, mem_req_valid=1 and mem_req_addr = {pt[63:12], vpn[level], 3'b000}; both zero in other states.
REQ-024 mem_resp_valid outside FETCH SHALL be ignored.
REQ-025 On PTE with V=0, or W=1 and R=0: DONE with fault.
REQ-026 On pointer PTE (R=W=X=0): level 0 -> DONE with fault; else pt <= {8'b0, pte[53:10], 12'b0}, level <= level-1, stay FETCH.
REQ-027 On leaf PTE: any ppn[i]!=0 for i<level (misaligned superpage) -> DONE with fault; else DONE, store PTE, fill cache (tag, PTE, level).
REQ-028 In DONE (exactly one cycle, then IDLE): resp_addr = {8'b0, ppn[43:9*level], VA[12+9*level-1:12], 12'b0}, resp_perms = PTE[7:0]; on fault both zero, resp_fault=1.
REQ-029 resp_valid[port] SHALL assert in DONE only if req_valid[port]=1 and req_addr[port][63:12] == latched VA[63:12]; otherwise the result is dropped (cache fill still kept).
REQ-030 Faults SHALL never fill the cache.
REQ-031 flush SHALL clear the cache entry next edge; in FETCH it SHALL abort to IDLE with no response; flush at the FETCH->DONE edge SHALL abort (no fill, no response); in DONE the response is still delivered but the entry is cleared; in IDLE it blocks acceptance that cycle.
REQ-032 Latency: hit/canonical fault = response 1 cycle after accept; miss = one FETCH per level plus 1 DONE cycle.
REQ-033 All outputs except busy SHALL be zero outside DONE.

Reset
REQ-034 Asynchronous reset SHALL force IDLE, rr_ptr=0, cache invalid, level=0, latched VA/PTE zero; all outputs zero; an in-flight walk is discarded and a later mem_resp_valid ignored.

Verification
REQ-035 LEVELS=4, root 0x1000, port0 VA 0x203ABC; PTEs 0x1000->0x801, 0x2000->0xC01, 0x3008->0x1001, 0x4018->0x280CF -> four mem reads at those addresses, resp_valid=01, resp_addr 0xA0000, perms 0xCF, fault 0.
REQ-036 Same VA repeated -> no mem_req_valid, resp 1 cycle after accept, same data; after flush -> full 4-read walk again.
REQ-037 0x3008 returns 0x800CF (2 MiB leaf) -> resp_addr 0x203000; returns 0x804CF (ppn 0x201) -> resp_fault=1, no fill.
REQ-038 VA 0x0001_0000_0000_0000 (LEVELS=4) -> fault, zero mem reads; PTE 0x0 or 0x5 at any level -> fault.
REQ-039 NPORTS=2, both ports held valid on distinct VAs -> grants alternate 0,1,0; port1 VA changed during its walk -> no resp_valid; reset asserted mid-FETCH -> IDLE immediately, late mem_resp_valid ignored.
